spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  SPI-mode-0 slave command controller that sequences the serial datapath into register accesses.
//  Oversamples the SPI pins in the system clock domain, frames bytes and decodes command/data bytes.
//  Drives the segment controller register file (write strobes, read data back on MISO).
//  Sits between the chip pins and the display register file; spi_clk >= 8x slower than clk.
// PARAMETERS
//  NUM_REGS     8   number of addressable registers; power of two, 2..16
//  ADDR_W       3   register address width; must equal log2(NUM_REGS)
//  SYNC_STAGES  2   flip-flop stages on each SPI input; minimum 2
// PORTS
//  clk        in   1       system clock; all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  spi_cs_n   in   1       chip select, active low (asynchronous to clk)
//  spi_sck    in   1       SPI clock, idle low (asynchronous to clk)
//  spi_mosi   in   1       serial data in, MSB first
//  spi_miso   out  1       serial data out, MSB first; 0 when not driving a read
//  reg_addr   out  ADDR_W  current register address
//  reg_wdata  out  8       write data; valid while reg_wr_en=1
//  reg_wr_en  out  1       one-clk write strobe
//  reg_rdata  in   8       combinational read data for reg_addr
//  busy       out  1       1 while a frame is active (synced cs_n low)
//  cmd_err    out  1       one-clk pulse on an invalid command byte
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift/bit counters 0, sync chains 0 (cs_n chain to 1).
//  Sync: cs_n, sck, mosi through SYNC_STAGES FFs; sck rise/fall detected from last two stages.
//  Shifting: on sck rise, rx_shift <= {rx_shift[6:0], mosi_s}, bit_cnt++ (3 bits, wraps 7->0).
//  Byte done: the clk after the rise that captures bit 0 (bit_cnt 7->0).
//  States: IDLE, CMD, WRITE, READ, DISCARD.
//   IDLE: cs_n_s falls -> CMD; bit_cnt cleared; busy=1.
//   CMD byte done: bit7=1 read, 0 write; bits[ADDR_W-1:0] -> reg_addr.
//     bits[6:ADDR_W] nonzero -> cmd_err pulse (same clk), state DISCARD, no accesses.
//     write -> WRITE. read -> READ; tx_shift <= reg_rdata sampled that same clk.
//   WRITE byte done: reg_wdata <= rx byte, reg_wr_en=1 exactly that one clk;
//     next clk reg_addr <= reg_addr+1 (wraps NUM_REGS-1 -> 0); stays WRITE (burst).
//   READ: spi_miso = tx_shift[7]; on each sck fall after the first read-byte bit,
//     tx_shift shifts left; byte done -> reg_addr+1 (wrap), next clk tx_shift <= reg_rdata.
//     First MISO bit valid before the first sck rise of the data byte (loaded at cmd done).
//   DISCARD: ignores all sck edges until cs_n_s rises.
//  spi_miso = 0 in IDLE, CMD, WRITE, DISCARD.
//  cs_n_s rise in any state -> IDLE next clk; partial byte discarded, no write strobe;
//    busy=0, spi_miso=0, reg_addr holds last value.
//  cs_n_s rise same clk as write byte done: the write completes (strobe issued), then IDLE.
//  Simultaneous sck edge and cs_n rise: cs_n wins except for the byte-done case above.
//  Async rst mid-frame: everything to reset values immediately; no strobe that clk.
//  Latency: pin edge to internal action = SYNC_STAGES+1 clks.
// TESTING
//  Write: cs low, send 0x03 then 0xA5, cs high -> one reg_wr_en, reg_addr=3, reg_wdata=0xA5.
//  Burst wrap: send 0x07,0x11,0x22 -> strobes (addr 7,0x11) then (addr 0,0x22).
//  Read: reg[2]=0x3C, send 0x82 then 8 dummy clocks -> MISO bits 0,0,1,1,1,1,0,0; writes none.
//  Abort: 0x01 then 5 data bits, cs high -> no reg_wr_en; next frame decodes normally.
//  Bad cmd: NUM_REGS=8, send 0x48 then 0xFF -> one cmd_err pulse, no reg_wr_en, miso=0.
//  Reset: assert rst mid data byte -> outputs 0, state IDLE; following 0x05,0x99 writes addr 5.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_reg_ctrl : SPI mode-0 slave that turns command/data bytes into         |
// |                register-file writes and MISO read-back.                    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module spi_reg_ctrl #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr_en,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] cs_n_q, cs_n_d;
  logic [SYNC_STAGES-1:0] sck_q, sck_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_en_q, wr_en_d;
  logic              cmd_err_q, cmd_err_d;
  logic              busy_q, busy_d;
  logic              miso_q, miso_d;
  logic              byte_done_q, byte_done_d;
  logic              load_q, load_d;

  logic cs_n_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic cmd_bad;

  // Index 0 is the stage nearest the pin; the last stage is the synced value.
  assign cs_n_s   = cs_n_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign sck_rise = sck_q[SYNC_STAGES-2] & ~sck_q[SYNC_STAGES-1];
  assign sck_fall = ~sck_q[SYNC_STAGES-2] & sck_q[SYNC_STAGES-1];
  assign cmd_bad  = |(rx_q[6:0] >> ADDR_W);

  always_comb begin
    cs_n_d      = {cs_n_q[SYNC_STAGES-2:0], spi_cs_n};
    sck_d       = {sck_q[SYNC_STAGES-2:0], spi_sck};
    mosi_d      = {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_en_d     = 1'b0;
    cmd_err_d   = 1'b0;
    byte_done_d = 1'b0;
    load_d      = 1'b0;

    // Burst write: advance the address the clock after each strobe.
    if (wr_en_q) begin
      addr_d = addr_q + c_addr_one;
    end

    if (cs_n_s && (state_q != IDLE)) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      if ((state_q == WRITE) && byte_done_q) begin
        wdata_d = rx_q;
        wr_en_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = 3'd0;
          if (!cs_n_s) begin
            state_d = CMD;
          end
        end
        CMD, WRITE, READ: begin
          if (sck_rise) begin
            rx_d        = {rx_q[6:0], mosi_s};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_d = (bit_cnt_q == 3'd7);
          end
          // The fall that ends a byte (bit_cnt back at 0) must not shift:
          // the freshly loaded MSB has to survive until the next rise.
          if ((state_q == READ) && sck_fall && (bit_cnt_q != 3'd0)) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
          if (byte_done_q) begin
            case (state_q)
              CMD: begin
                if (cmd_bad) begin
                  cmd_err_d = 1'b1;
                  state_d   = DISCARD;
                end else begin
                  addr_d  = rx_q[ADDR_W-1:0];
                  state_d = rx_q[7] ? READ : WRITE;
                  load_d  = rx_q[7];
                  tx_d    = 8'h00;
                end
              end
              WRITE: begin
                wdata_d = rx_q;
                wr_en_d = 1'b1;
              end
              READ: begin
                addr_d = addr_q + c_addr_one;
                load_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        DISCARD: ;
        default: state_d = IDLE;
      endcase
    end

    // reg_rdata follows reg_addr, so the load waits one clock for the new address.
    if (load_q) begin
      tx_d = reg_rdata;
    end

    busy_d = (state_d != IDLE);
    miso_d = (state_d == READ) ? tx_d[7] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_q      <= {SYNC_STAGES{1'b1}};
      sck_q       <= '0;
      mosi_q      <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      wr_en_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      byte_done_q <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      cmd_err_q   <= cmd_err_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      byte_done_q <= byte_done_d;
      load_q      <= load_d;
    end
  end

  assign spi_miso  = miso_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_reg_ctrl : SPI master stimulus against a frame-level reference model |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_spi_reg_ctrl;
  localparam int HALF = 8;  // clk cycles per sck half period

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n, sck, mosi, miso;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       reg_wr_en, busy, cmd_err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem   [8];
  logic [7:0]  model [8];
  logic [10:0] obs_wr[$];
  int          err_cnt = 0;

  logic [7:0]  xb [16];
  logic [7:0]  rb [16];
  int          xn, xtail;
  logic        busy_seen;

  logic [10:0] exp_wr[$];
  logic [7:0]  exp_rb[16];
  int          exp_err;
  logic [2:0]  exp_addr = 3'd0;
  bit          addr_known = 1'b1;

  spi_reg_ctrl #(.NUM_REGS(8), .ADDR_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi),
    .spi_miso(miso), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en), .reg_rdata(reg_rdata), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  assign reg_rdata = mem[reg_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else begin
      if (reg_wr_en) begin
        obs_wr.push_back({reg_addr, reg_wdata});
        mem[reg_addr] <= reg_wdata;
      end
      if (cmd_err) err_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b, output logic m);
    @(negedge clk);
    mosi = b;
    repeat (HALF) @(negedge clk);
    m   = miso;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  // Frame: xn whole bytes from xb, then xtail leading bits of xb[xn].
  task automatic spi_xfer();
    logic m;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    busy_seen = busy;
    for (int i = 0; i < 16; i++) rb[i] = 8'h00;
    for (int i = 0; i < xn; i++)
      for (int j = 7; j >= 0; j--) begin
        spi_bit(xb[i][j], m);
        rb[i][j] = m;
      end
    for (int j = 7; j >= 8 - xtail; j--) spi_bit(xb[xn][j], m);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Expected effect of one frame, derived from the command byte rules.
  task automatic model_frame();
    logic [2:0] a;
    exp_wr.delete();
    exp_err = 0;
    for (int i = 0; i < 16; i++) exp_rb[i] = 8'h00;
    if (xn == 0) return;
    if (xb[0][6:3] != 4'd0) begin
      exp_err    = 1;
      addr_known = 1'b0;
      return;
    end
    a = xb[0][2:0];
    for (int i = 1; i < xn; i++) begin
      if (xb[0][7]) exp_rb[i] = model[a];
      else begin
        exp_wr.push_back({a, xb[i]});
        model[a] = xb[i];
      end
      a = 3'((int'(a) + 1) % 8);
    end
    exp_addr   = a;
    addr_known = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({miso, reg_addr, reg_wdata, reg_wr_en, busy, cmd_err} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {miso, reg_addr, reg_wdata, reg_wr_en, busy, cmd_err});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({busy, reg_wr_en, miso} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got %b want 000", {busy, reg_wr_en, miso});
    end
  endtask

  task automatic test_write();
    int w0 = obs_wr.size();
    xn = 2; xtail = 0; xb[0] = 8'h03; xb[1] = 8'hA5;
    model_frame();
    spi_xfer();
    total++;
    if (busy_seen !== 1'b1) begin bad++; $display("FAIL write_busy: got %b want 1", busy_seen); end
    total++;
    if (obs_wr.size() - w0 != 1) begin
      bad++; $display("FAIL write_count: got %0d want 1", obs_wr.size() - w0);
    end else begin
      total++;
      if (obs_wr[w0] !== {3'd3, 8'hA5}) begin
        bad++; $display("FAIL write_data: got %h want %h", obs_wr[w0], {3'd3, 8'hA5});
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_burst_wrap();
    int w0 = obs_wr.size();
    xn = 3; xtail = 0; xb[0] = 8'h07; xb[1] = 8'h11; xb[2] = 8'h22;
    model_frame();
    spi_xfer();
    total++;
    if (obs_wr.size() - w0 != 2) begin
      bad++; $display("FAIL burst_count: got %0d want 2", obs_wr.size() - w0);
    end else begin
      total++;
      if ({obs_wr[w0], obs_wr[w0+1]} !== {3'd7, 8'h11, 3'd0, 8'h22}) begin
        bad++; $display("FAIL burst_data: got %h %h want 711 022", obs_wr[w0], obs_wr[w0+1]);
      end
    end
    total++;
    if (reg_addr !== 3'd1) begin bad++; $display("FAIL burst_addr: got %0d want 1", reg_addr); end
  endtask

  task automatic test_read();
    int w0;
    xn = 2; xtail = 0; xb[0] = 8'h02; xb[1] = 8'h3C;
    model_frame();
    spi_xfer();
    w0 = obs_wr.size();
    xn = 3; xb[0] = 8'h82; xb[1] = 8'h00; xb[2] = 8'h00;
    model_frame();
    spi_xfer();
    total++;
    if (rb[1] !== 8'h3C) begin bad++; $display("FAIL read_reg2: got %h want 3c", rb[1]); end
    total++;
    if (rb[2] !== 8'hA5) begin bad++; $display("FAIL read_reg3: got %h want a5", rb[2]); end
    total++;
    if (rb[0] !== 8'h00) begin bad++; $display("FAIL read_cmd_miso: got %h want 00", rb[0]); end
    total++;
    if (obs_wr.size() != w0) begin
      bad++; $display("FAIL read_no_write: got %0d want 0", obs_wr.size() - w0);
    end
    total++;
    if (miso !== 1'b0) begin bad++; $display("FAIL read_miso_idle: got %b want 0", miso); end
  endtask

  task automatic test_abort();
    int w0 = obs_wr.size();
    xn = 1; xtail = 5; xb[0] = 8'h01; xb[1] = 8'($urandom);
    model_frame();
    spi_xfer();
    total++;
    if (obs_wr.size() != w0) begin
      bad++; $display("FAIL abort_no_write: got %0d want 0", obs_wr.size() - w0);
    end
    total++;
    if (reg_addr !== 3'd1) begin bad++; $display("FAIL abort_addr: got %0d want 1", reg_addr); end
    xn = 2; xtail = 0; xb[0] = 8'h06; xb[1] = 8'h5A;
    model_frame();
    spi_xfer();
    total++;
    if (obs_wr.size() - w0 != 1 || obs_wr[w0] !== {3'd6, 8'h5A}) begin
      bad++; $display("FAIL abort_next: got n=%0d want one write 65a", obs_wr.size() - w0);
    end
  endtask

  task automatic test_bad_cmd();
    int w0 = obs_wr.size();
    int e0 = err_cnt;
    xn = 2; xtail = 0; xb[0] = 8'h48; xb[1] = 8'hFF;
    model_frame();
    spi_xfer();
    total++;
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL bad_cmd_err: got %0d want 1", err_cnt - e0); end
    total++;
    if (obs_wr.size() != w0) begin
      bad++; $display("FAIL bad_cmd_no_write: got %0d want 0", obs_wr.size() - w0);
    end
    total++;
    if ({rb[0], rb[1]} !== 16'h0000) begin
      bad++; $display("FAIL bad_cmd_miso: got %h want 0000", {rb[0], rb[1]});
    end
  endtask

  task automatic test_reset_mid();
    logic m;
    logic [7:0] c = 8'h01;
    int w0 = obs_wr.size();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int j = 7; j >= 0; j--) spi_bit(c[j], m);
    for (int j = 0; j < 4; j++) spi_bit(1'b1, m);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({miso, reg_addr, reg_wdata, reg_wr_en, busy, cmd_err} !== 15'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %h want 0", {miso, reg_addr, reg_wdata, reg_wr_en, busy, cmd_err});
    end
    cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    exp_addr = 3'd0; addr_known = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (obs_wr.size() != w0) begin
      bad++; $display("FAIL reset_mid_no_write: got %0d want 0", obs_wr.size() - w0);
    end
    xn = 2; xtail = 0; xb[0] = 8'h05; xb[1] = 8'h99;
    model_frame();
    spi_xfer();
    total++;
    if (obs_wr.size() - w0 != 1 || obs_wr[w0] !== {3'd5, 8'h99}) begin
      bad++; $display("FAIL reset_mid_next: got n=%0d want one write 599", obs_wr.size() - w0);
    end
  endtask

  task automatic test_random();
    int w0, e0;
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(3) != 0) xb[0] = {1'($urandom), 4'd0, 3'($urandom)};
      else begin
        xb[0] = 8'($urandom);
        if (xb[0][6:3] == 4'd0) xb[0][4] = 1'b1;
      end
      xn    = $urandom_range(4);
      xtail = ($urandom_range(2) == 0) ? $urandom_range(1, 7) : 0;
      if (xn == 0 && xtail == 0) xn = 1;
      for (int i = 1; i < 6; i++) xb[i] = 8'($urandom);
      w0 = obs_wr.size();
      e0 = err_cnt;
      model_frame();
      spi_xfer();
      total++;
      if (busy_seen !== 1'b1) begin bad++; $display("FAIL rnd_busy f%0d: got %b want 1", f, busy_seen); end
      total++;
      if (obs_wr.size() - w0 != exp_wr.size()) begin
        bad++; $display("FAIL rnd_wr_count f%0d: got %0d want %0d", f, obs_wr.size() - w0, exp_wr.size());
      end else begin
        for (int i = 0; i < exp_wr.size(); i++) begin
          total++;
          if (obs_wr[w0+i] !== exp_wr[i]) begin
            bad++; $display("FAIL rnd_wr f%0d.%0d: got %h want %h", f, i, obs_wr[w0+i], exp_wr[i]);
          end
        end
      end
      total++;
      if (err_cnt - e0 != exp_err) begin
        bad++; $display("FAIL rnd_err f%0d: got %0d want %0d", f, err_cnt - e0, exp_err);
      end
      for (int i = 0; i < xn; i++) begin
        total++;
        if (rb[i] !== exp_rb[i]) begin
          bad++; $display("FAIL rnd_miso f%0d.%0d: got %h want %h", f, i, rb[i], exp_rb[i]);
        end
      end
      if (addr_known) begin
        total++;
        if (reg_addr !== exp_addr) begin
          bad++; $display("FAIL rnd_addr f%0d: got %0d want %0d", f, reg_addr, exp_addr);
        end
      end
      total++;
      if ({busy, miso} !== 2'b00) begin
        bad++; $display("FAIL rnd_idle f%0d: got %b want 00", f, {busy, miso});
      end
    end
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_burst_wrap();
    test_read();
    test_abort();
    test_bad_cmd();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
